spi_minion: RTL and testbench

- Receiving end of the team's SPI link: the peripheral that the SPI master FSM drives, in mode 0 (CPOL=0, CPHA=0), MSB first.
- Oversamples the external cs/sclk/mosi pins on the system clock and deserializes each frame.
- Delivers each complete received word on a val/rdy send interface.
- Serializes one buffered response word, taken from a val/rdy recv interface, onto miso during the next frame.

---
 rtl/spi_minion_if.sv | 37 +++
 rtl/spi_minion.sv | 141 ++++++++++++++
 tb/tb_spi_minion.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_minion_if.sv
// spi_minion_if: bundles the SPI pins and the two val/rdy word interfaces of
// the SPI minion.
//   cs, sclk, mosi             : serial inputs from the SPI master
//   miso                       : serial output to the SPI master
//   recv_val/recv_rdy/recv_msg : response word into the minion
//   send_val/send_rdy/send_msg : received word out of the minion
//   overflow                   : one-cycle pulse when a full frame is dropped
//   active                     : debug view of the minion FSM (1 = ACTIVE)
// Handshake rule for both word interfaces: a word moves on a clock edge where
// val and rdy are both high; the producer holds val and msg stable until then.
// Modports: slave = the minion itself, master = whoever drives the link.
interface spi_minion_if #(
    parameter int nbits = 8
);
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             recv_val;
    logic             recv_rdy;
    logic [nbits-1:0] recv_msg;
    logic             send_val;
    logic             send_rdy;
    logic [nbits-1:0] send_msg;
    logic             overflow;
    logic             active;

    modport slave (
        input  cs, sclk, mosi, recv_val, recv_msg, send_rdy,
        output miso, recv_rdy, send_val, send_msg, overflow, active
    );

    modport master (
        output cs, sclk, mosi, recv_val, recv_msg, send_rdy,
        input  miso, recv_rdy, send_val, send_msg, overflow, active
    );
endinterface

// File: rtl/spi_minion.sv
// spi_minion: SPI mode 0 (CPOL=0, CPHA=0), MSB-first peripheral.
// The cs/sclk/mosi pins are oversampled on clk, each frame is deserialized and
// delivered on the send interface; one buffered response word taken from the
// recv interface is shifted out on miso during the next frame.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : spi_minion_if.slave (pins, recv/send handshakes, overflow, active)
// Optional build macro SPI_MINION_LOOPBACK_EN: when no response word is
// buffered at frame start, the last accepted received word is echoed instead
// of zeros.
module spi_minion #(
    parameter int nbits = 8
) (
    input  logic         clk,
    input  logic         reset,
    spi_minion_if.slave  bus
);
    localparam int cw = $clog2(nbits + 2);
    localparam logic [cw-1:0] cnt_full = cw'(nbits);
    localparam logic [cw-1:0] cnt_sat  = cw'(nbits + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       cs_s;
    logic [2:0]       sclk_s;
    logic [2:0]       mosi_s;
    logic [cw-1:0]    bit_cnt;
    logic [nbits-1:0] rx_shift;
    logic [nbits-1:0] tx_shift;
    logic [nbits-1:0] tx_buf;
    logic             tx_full;
    logic [nbits-1:0] send_msg_r;
    logic             send_val_r;
    logic             overflow_r;
    logic [nbits-1:0] empty_word;

    // Stage [1] is the second synchronizer flop, stage [2] the edge-detect flop.
    logic cs_fall, cs_rise, sclk_rise, sclk_fall, recv_rdy_int;
    assign cs_fall   = cs_s[2] & ~cs_s[1];
    assign cs_rise   = ~cs_s[2] & cs_s[1];
    assign sclk_rise = ~sclk_s[2] & sclk_s[1];
    assign sclk_fall = sclk_s[2] & ~sclk_s[1];

    assign recv_rdy_int = ~tx_full & ~reset;

`ifdef SPI_MINION_LOOPBACK_EN
    logic [nbits-1:0] last_rx;
    assign empty_word = last_rx;
`else
    assign empty_word = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cs_s       <= 3'b111;
            sclk_s     <= 3'b000;
            mosi_s     <= 3'b000;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_buf     <= '0;
            tx_full    <= 1'b0;
            send_msg_r <= '0;
            send_val_r <= 1'b0;
            overflow_r <= 1'b0;
`ifdef SPI_MINION_LOOPBACK_EN
            last_rx    <= '0;
`endif
        end else begin
            cs_s       <= {cs_s[1:0], bus.cs};
            sclk_s     <= {sclk_s[1:0], bus.sclk};
            mosi_s     <= {mosi_s[1:0], bus.mosi};
            overflow_r <= 1'b0;

            if (send_val_r && bus.send_rdy) begin
                send_val_r <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        bit_cnt  <= '0;
                        tx_shift <= tx_full ? tx_buf : empty_word;
                        tx_full  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        if (bit_cnt == cnt_full) begin
                            // A word leaving this cycle frees the buffer for the new one.
                            if (!send_val_r || bus.send_rdy) begin
                                send_msg_r <= rx_shift;
                                send_val_r <= 1'b1;
`ifdef SPI_MINION_LOOPBACK_EN
                                last_rx    <= rx_shift;
`endif
                            end else begin
                                overflow_r <= 1'b1;
                            end
                        end
                    end else begin
                        if (sclk_rise) begin
                            if (bit_cnt < cnt_full) begin
                                rx_shift <= {rx_shift[nbits-2:0], mosi_s[2]};
                            end
                            if (bit_cnt != cnt_sat) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            tx_shift <= {tx_shift[nbits-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a load coinciding with ACTIVE entry keeps
            // tx_full set: the new word waits for the following frame.
            if (bus.recv_val && recv_rdy_int) begin
                tx_buf  <= bus.recv_msg;
                tx_full <= 1'b1;
            end
        end
    end

    assign bus.miso     = (state == ACTIVE) & tx_shift[nbits-1];
    assign bus.recv_rdy = recv_rdy_int;
    assign bus.send_val = send_val_r;
    assign bus.send_msg = send_msg_r;
    assign bus.overflow = overflow_r;
    assign bus.active   = (state == ACTIVE);
endmodule

// File: tb/tb_spi_minion.sv
// tb_spi_minion: directed bench for spi_minion (nbits = 8), mode 0 master
// driven with 8-clk sclk phases.
module tb_spi_minion;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   ovf_cnt;
    logic [15:0] rx;

    spi_minion_if #(.nbits(8)) bus ();

    spi_minion #(.nbits(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // overflow pulse counter, sampled mid-cycle
    initial ovf_cnt = 0;
    always @(negedge clk) if (bus.overflow === 1'b1) ovf_cnt++;

`ifdef SPI_MINION_LOOPBACK_EN
    localparam bit lb = 1'b1;
`else
    localparam bit lb = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame of npulse sclk pulses, MSB of data[npulse-1:0] first.
    // miso is captured just before each sclk rise. If rv_at >= 0, recv_val is
    // raised with rv_msg rv_at+1 negedges after cs falls, for rv_len cycles.
    task automatic frame(input logic [15:0] data, input int npulse,
                         input int rv_at, input int rv_len, input logic [7:0] rv_msg,
                         output logic [15:0] got);
        got = '0;
        bus.cs = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == rv_at) begin
                bus.recv_val = 1'b1;
                bus.recv_msg = rv_msg;
            end
            if (rv_at >= 0 && k == rv_at + rv_len) bus.recv_val = 1'b0;
        end
        for (int i = 0; i < npulse; i++) begin
            bus.mosi = data[npulse-1-i];
            repeat (8) @(negedge clk);
            got = {got[14:0], bus.miso};
            bus.sclk = 1'b1;
            repeat (8) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] w);
        bus.recv_val = 1'b1;
        bus.recv_msg = w;
        @(negedge clk);
        bus.recv_val = 1'b0;
    endtask

    // Wait for the word, check it, then consume it with one handshake.
    task automatic expect_word(input string tag, input logic [7:0] w);
        repeat (12) @(negedge clk);
        check({tag, "_val"}, 32'(bus.send_val), 32'd1);
        check({tag, "_msg"}, 32'(bus.send_msg), 32'(w));
        bus.send_rdy = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_clr"}, 32'(bus.send_val), 32'd0);
        @(negedge clk);
        bus.send_rdy = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.cs = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.recv_val = 1'b0;
        bus.recv_msg = '0;
        bus.send_rdy = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_send_val", 32'(bus.send_val), 32'd0);
        check("rst_send_msg", 32'(bus.send_msg), 32'd0);
        check("rst_recv_rdy", 32'(bus.recv_rdy), 32'd0);
        check("rst_miso", 32'(bus.miso), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_recv_rdy", 32'(bus.recv_rdy), 32'd1);

        // basic frame: response 0xA5, master sends 0x3C
        load_word(8'hA5);
        check("t1_rdy_full", 32'(bus.recv_rdy), 32'd0);
        frame(16'h003C, 8, -1, 0, 8'h00, rx);
        check("t1_miso", 32'(rx), 32'h00A5);
        check("t1_rdy_free", 32'(bus.recv_rdy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t1_val_early", 32'(bus.send_val), 32'd0);
        @(posedge clk);
        #1;
        check("t1_val_3cyc", 32'(bus.send_val), 32'd1);
        check("t1_msg_3cyc", 32'(bus.send_msg), 32'h3C);
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("t1_val_held", 32'(bus.send_val), 32'd1);
        expect_word("t1", 8'h3C);

        // overflow: 0x11 then 0x22 without consuming
        frame(16'h0011, 8, -1, 0, 8'h00, rx);
        check("t2_miso_underflow0", 32'(rx), lb ? 32'h3C : 32'h00);
        repeat (12) @(negedge clk);
        check("t2_first_msg", 32'(bus.send_msg), 32'h11);
        frame(16'h0022, 8, -1, 0, 8'h00, rx);
        repeat (2) @(posedge clk);
        #1;
        check("t2_ovf_early", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1;
        check("t2_ovf_pulse", 32'(bus.overflow), 32'd1);
        @(posedge clk);
        #1;
        check("t2_ovf_end", 32'(bus.overflow), 32'd0);
        check("t2_msg_kept", 32'(bus.send_msg), 32'h11);
        @(negedge clk);
        expect_word("t2", 8'h11);
        check("t2_ovf_count", 32'(ovf_cnt), 32'd1);

        // short (5) and long (9) frames are discarded
        frame(16'h0015, 5, -1, 0, 8'h00, rx);
        repeat (12) @(negedge clk);
        check("t3_short_val", 32'(bus.send_val), 32'd0);
        frame(16'h01FF, 9, -1, 0, 8'h00, rx);
        repeat (12) @(negedge clk);
        check("t3_long_val", 32'(bus.send_val), 32'd0);
        check("t3_ovf_count", 32'(ovf_cnt), 32'd1);
        frame(16'h0081, 8, -1, 0, 8'h00, rx);
        expect_word("t3", 8'h81);

        // underflow: nothing buffered
        frame(16'h00FF, 8, -1, 0, 8'h00, rx);
        check("t4_miso", 32'(rx), lb ? 32'h81 : 32'h00);
        check("t4_rdy", 32'(bus.recv_rdy), 32'd1);
        expect_word("t4", 8'hFF);
        frame(16'h0000, 8, -1, 0, 8'h00, rx);
        check("t4_miso_next", 32'(rx), lb ? 32'hFF : 32'h00);
        expect_word("t4b", 8'h00);

        // reset after 4 bits of 0xF0, released with cs still low
        bus.cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                repeat (2) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                check("t5_rst_active", 32'(bus.active), 32'd0);
                reset = 1'b0;
                repeat (8) @(negedge clk);
            end
            bus.mosi = (i < 4);
            repeat (8) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (8) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        bus.cs = 1'b1;
        bus.mosi = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_no_val", 32'(bus.send_val), 32'd0);
        check("t5_ovf_count", 32'(ovf_cnt), 32'd1);
        frame(16'h005A, 8, -1, 0, 8'h00, rx);
        expect_word("t5", 8'h5A);

        // recv word offered at ACTIVE entry while 0x66 is buffered
        load_word(8'h66);
        frame(16'h0012, 8, 1, 3, 8'h99, rx);
        check("t6_miso_old", 32'(rx), 32'h66);
        check("t6_rdy_full", 32'(bus.recv_rdy), 32'd0);
        expect_word("t6", 8'h12);
        frame(16'h0034, 8, -1, 0, 8'h00, rx);
        check("t6_miso_new", 32'(rx), 32'h99);
        expect_word("t6b", 8'h34);

        // single-cycle load exactly at ACTIVE entry with empty buffer
        frame(16'h0056, 8, 1, 1, 8'h3C, rx);
        check("t7_miso_empty", 32'(rx), lb ? 32'h34 : 32'h00);
        expect_word("t7", 8'h56);
        frame(16'h0078, 8, -1, 0, 8'h00, rx);
        check("t7_miso_held", 32'(rx), 32'h3C);
        expect_word("t7b", 8'h78);
        check("end_ovf_count", 32'(ovf_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // overall time bound
    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
